// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-master memory bus arbiter.
package mem_arb_pkg;

  localparam int NUM_MASTERS = 2;
  localparam logic [31:0] ERR_RDATA_DEFAULT = 32'hDEADBEEF;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_BUSY = 2'd1,
    ARB_DONE = 2'd2
  } arb_state_t;

  // One captured request as forwarded to the slave
  typedef struct packed {
    logic        instr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } mem_req_t;

  // Width of a counter able to hold values 0..limit
  function automatic int unsigned tmo_width(input int unsigned limit);
    int unsigned w;
    w = $clog2(limit + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/mem_arb_rr_pick.sv
// Combinational 2-way round-robin picker: a tie goes to the master that
// did not own the previous transaction; a lone request always wins.
module mem_arb_rr_pick (
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic [1:0] grant
);

  // Resolve the tie against last_grant, otherwise pass the lone request through
  always_comb begin
    grant = 2'b00;
    if (req == 2'b11) begin
      grant = last_grant ? 2'b01 : 2'b10;
    end else begin
      grant = req;
    end
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Two-master arbiter in front of one picorv32-style native memory port.
// One whole transaction is granted at a time (IDLE -> BUSY -> DONE).
// Optional slave-response timeout: define MEM_ARB_TIMEOUT_EN.
module mem_bus_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 256,
  parameter logic [31:0] ERR_RDATA      = ERR_RDATA_DEFAULT
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        m0_valid,
  input  logic        m0_instr,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic [3:0]  m0_wstrb,
  output logic        m0_ready,
  output logic [31:0] m0_rdata,
  input  logic        m1_valid,
  input  logic        m1_instr,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  input  logic [3:0]  m1_wstrb,
  output logic        m1_ready,
  output logic [31:0] m1_rdata,
  output logic        s_valid,
  output logic        s_instr,
  output logic [31:0] s_addr,
  output logic [31:0] s_wdata,
  output logic [3:0]  s_wstrb,
  input  logic        s_ready,
  input  logic [31:0] s_rdata,
  output logic [1:0]  grant,
  output logic        timeout_err
);

  arb_state_t             state_reg;
  logic                   last_grant_reg;
  logic [NUM_MASTERS-1:0] grant_reg;
  logic                   s_valid_reg;
  mem_req_t               s_req_reg;

  logic [NUM_MASTERS-1:0] m_valid;
  mem_req_t               m_req [NUM_MASTERS];
  logic [NUM_MASTERS-1:0] pick_grant;
  mem_req_t               win_req;

  logic                   timeout_hit;
  logic                   complete;
  logic [31:0]            rsp_data;

  logic [NUM_MASTERS-1:0] rsp_ready_reg;
  logic [31:0]            rsp_rdata_reg [NUM_MASTERS];

  assign m_valid  = {m1_valid, m0_valid};
  assign m_req[0] = '{instr: m0_instr, addr: m0_addr, wdata: m0_wdata, wstrb: m0_wstrb};
  assign m_req[1] = '{instr: m1_instr, addr: m1_addr, wdata: m1_wdata, wstrb: m1_wstrb};

  mem_arb_rr_pick u_pick (
    .req        (m_valid),
    .last_grant (last_grant_reg),
    .grant      (pick_grant)
  );

  assign win_req  = pick_grant[1] ? m_req[1] : m_req[0];

  // A BUSY cycle finishes on slave ready, or on timeout when enabled;
  // s_ready seen on the limit cycle still counts as a normal completion.
  assign complete = (state_reg == ARB_BUSY) && (s_ready || timeout_hit);
  assign rsp_data = s_ready ? s_rdata : ERR_RDATA;

  // Transaction FSM: capture winner in IDLE, wait for slave in BUSY, retire in DONE
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_reg      <= ARB_IDLE;
      last_grant_reg <= 1'b1;
      grant_reg      <= '0;
      s_valid_reg    <= 1'b0;
      s_req_reg      <= '0;
    end else begin
      case (state_reg)
        ARB_IDLE: begin
          if (|m_valid) begin
            s_req_reg   <= win_req;
            s_valid_reg <= 1'b1;
            grant_reg   <= pick_grant;
            state_reg   <= ARB_BUSY;
          end
        end
        ARB_BUSY: begin
          if (complete) begin
            s_valid_reg <= 1'b0;
            state_reg   <= ARB_DONE;
          end
        end
        ARB_DONE: begin
          last_grant_reg <= grant_reg[1];
          grant_reg      <= '0;
          state_reg      <= ARB_IDLE;
        end
        default: begin
          grant_reg   <= '0;
          s_valid_reg <= 1'b0;
          state_reg   <= ARB_IDLE;
        end
      endcase
    end
  end

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int unsigned           TMO_W    = tmo_width(TIMEOUT_CYCLES);
  localparam logic [TMO_W-1:0]      TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  logic [TMO_W-1:0] tmo_cnt_reg;
  logic             timeout_err_reg;

  // The counter holds the number of BUSY cycles already spent without s_ready
  assign timeout_hit = (state_reg == ARB_BUSY) && !s_ready && (tmo_cnt_reg == TMO_LAST);

  // Count stalled BUSY cycles; zero whenever not BUSY so each grant starts fresh
  always_ff @(posedge clk) begin
    if (!resetn) begin
      tmo_cnt_reg <= '0;
    end else if (state_reg != ARB_BUSY) begin
      tmo_cnt_reg <= '0;
    end else if (!s_ready) begin
      tmo_cnt_reg <= tmo_cnt_reg + 1'b1;
    end
  end

  // Error flag pulses alongside the owner's ready pulse of a timed-out transaction
  always_ff @(posedge clk) begin
    if (!resetn) begin
      timeout_err_reg <= 1'b0;
    end else begin
      timeout_err_reg <= timeout_hit;
    end
  end

  assign timeout_err = timeout_err_reg;
`else
  assign timeout_hit = 1'b0;
  assign timeout_err = 1'b0;
`endif

  // Per-master response registers: one-cycle ready pulse, rdata zero outside it
  for (genvar gi = 0; gi < NUM_MASTERS; gi++) begin : g_rsp
    always_ff @(posedge clk) begin
      if (!resetn) begin
        rsp_ready_reg[gi] <= 1'b0;
        rsp_rdata_reg[gi] <= '0;
      end else if (complete && grant_reg[gi]) begin
        rsp_ready_reg[gi] <= 1'b1;
        rsp_rdata_reg[gi] <= rsp_data;
      end else begin
        rsp_ready_reg[gi] <= 1'b0;
        rsp_rdata_reg[gi] <= '0;
      end
    end
  end

  assign m0_ready = rsp_ready_reg[0];
  assign m0_rdata = rsp_rdata_reg[0];
  assign m1_ready = rsp_ready_reg[1];
  assign m1_rdata = rsp_rdata_reg[1];

  assign s_valid  = s_valid_reg;
  assign s_instr  = s_req_reg.instr;
  assign s_addr   = s_req_reg.addr;
  assign s_wdata  = s_req_reg.wdata;
  assign s_wstrb  = s_req_reg.wstrb;
  assign grant    = grant_reg;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed scoreboard bench for mem_bus_arbiter (built with TIMEOUT_CYCLES=8).
module tb_mem_bus_arbiter;

  logic        clk = 1'b0;
  logic        resetn;
  logic [1:0]  mv;
  logic [1:0]  mi;
  logic [31:0] maddr  [2];
  logic [31:0] mwdata [2];
  logic [3:0]  mwstrb [2];
  logic        s_ready;
  logic [31:0] s_rdata;

  logic        m0_ready, m1_ready, s_valid, s_instr, timeout_err;
  logic [31:0] m0_rdata, m1_rdata, s_addr, s_wdata;
  logic [3:0]  s_wstrb;
  logic [1:0]  grant;

  typedef struct {
    int          owner;
    logic [31:0] data;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  bit   tb_last;

  always #5 clk = ~clk;

  mem_bus_arbiter #(.TIMEOUT_CYCLES(8)) dut (
    .clk         (clk),
    .resetn      (resetn),
    .m0_valid    (mv[0]),
    .m0_instr    (mi[0]),
    .m0_addr     (maddr[0]),
    .m0_wdata    (mwdata[0]),
    .m0_wstrb    (mwstrb[0]),
    .m0_ready    (m0_ready),
    .m0_rdata    (m0_rdata),
    .m1_valid    (mv[1]),
    .m1_instr    (mi[1]),
    .m1_addr     (maddr[1]),
    .m1_wdata    (mwdata[1]),
    .m1_wstrb    (mwstrb[1]),
    .m1_ready    (m1_ready),
    .m1_rdata    (m1_rdata),
    .s_valid     (s_valid),
    .s_instr     (s_instr),
    .s_addr      (s_addr),
    .s_wdata     (s_wdata),
    .s_wstrb     (s_wstrb),
    .s_ready     (s_ready),
    .s_rdata     (s_rdata),
    .grant       (grant),
    .timeout_err (timeout_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [1:0] oh(input int i);
    return (i == 1) ? 2'b10 : 2'b01;
  endfunction

  function automatic logic [31:0] rd(input int i);
    return (i == 1) ? m1_rdata : m0_rdata;
  endfunction

  // Reference round-robin: tie goes to the master that was not last served
  function automatic int model_pick(input logic [1:0] req, input bit last);
    if (req == 2'b11) return last ? 0 : 1;
    return req[1] ? 1 : 0;
  endfunction

  task automatic set_master(input int m, input logic instr, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic [3:0] wstrb);
    mi[m]     = instr;
    maddr[m]  = addr;
    mwdata[m] = wdata;
    mwstrb[m] = wstrb;
    mv[m]     = 1'b1;
  endtask

  task automatic do_reset();
    resetn  = 1'b0;
    s_ready = 1'b0;
    s_rdata = '0;
    tick();
    tick();
    resetn  = 1'b1;
    tb_last = 1'b1;
  endtask

  // Wait (bounded) for the slave request and verify the forwarded fields
  task automatic arbitrate(output int owner);
    int lat;
    int exp_o;
    exp_o = model_pick(mv, tb_last);
    lat = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      lat++;
      if (s_valid === 1'b1) break;
    end
    check("req_to_s_valid_cycles", 32'(lat), 32'd1);
    check("grant_busy", 32'(grant), 32'(oh(exp_o)));
    check("s_addr", s_addr, maddr[exp_o]);
    check("s_wdata", s_wdata, mwdata[exp_o]);
    check("s_wstrb", 32'(s_wstrb), 32'(mwstrb[exp_o]));
    check("s_instr", 32'(s_instr), 32'(mi[exp_o]));
    owner = exp_o;
  endtask

  // Slave answers after 'delay' stall cycles; optionally holds s_ready one extra cycle
  task automatic respond(input int owner, input int delay, input logic [31:0] data,
                         input bit hold, input bit drop);
    exp_t e;
    for (int i = 0; i < delay; i++) begin
      tick();
      check("s_valid_held", 32'(s_valid), 32'd1);
      check("s_addr_held", s_addr, maddr[owner]);
      check("no_early_ready", 32'({m1_ready, m0_ready}), 32'd0);
    end
    sb.push_back('{owner: owner, data: data});
    s_ready = 1'b1;
    s_rdata = data;
    tick();
    e = sb.pop_front();
    check("ready_pulse", 32'({m1_ready, m0_ready}), 32'(oh(e.owner)));
    check("owner_rdata", rd(e.owner), e.data);
    check("other_rdata", rd(1 - e.owner), 32'd0);
    check("s_valid_drop", 32'(s_valid), 32'd0);
    check("grant_done", 32'(grant), 32'(oh(e.owner)));
    check("timeout_err_normal", 32'(timeout_err), 32'd0);
    $display("txn: m%0d addr=0x%08h wstrb=0x%0h rdata=0x%08h", e.owner, maddr[e.owner],
             mwstrb[e.owner], rd(e.owner));
    if (drop) mv[owner] = 1'b0;
    tb_last = (owner == 1);
    s_ready = hold;
    s_rdata = $urandom;
    tick();
    s_ready = 1'b0;
    check("ready_one_cycle", 32'({m1_ready, m0_ready}), 32'd0);
    check("m0_rdata_idle", m0_rdata, 32'd0);
    check("m1_rdata_idle", m1_rdata, 32'd0);
    check("grant_idle", 32'(grant), 32'd0);
  endtask

  initial begin
    #300000;
    $fatal(1, "FAIL watchdog: simulation time limit reached");
  end

  initial begin
    int o;
    int rdy_seen;
    int err_seen;
    int lat;
    exp_t e;

    mv = 2'b11;
    mi = 2'b00;
    for (int i = 0; i < 2; i++) begin
      maddr[i]  = 32'h10 * i;
      mwdata[i] = '0;
      mwstrb[i] = '0;
    end

    // Reset with both masters requesting: nothing may leak out
    do_reset();
    mv = 2'b00;
    check("rst_s_valid", 32'(s_valid), 32'd0);
    check("rst_grant", 32'(grant), 32'd0);
    check("rst_ready", 32'({m1_ready, m0_ready}), 32'd0);
    check("rst_m0_rdata", m0_rdata, 32'd0);
    check("rst_m1_rdata", m1_rdata, 32'd0);
    check("rst_timeout_err", 32'(timeout_err), 32'd0);
    check("rst_s_addr", s_addr, 32'd0);

    // Single m0 read, slave answers after 3 cycles
    set_master(0, 1'b0, 32'h0000_0100, 32'h0, 4'h0);
    arbitrate(o);
    check("m0_read_owner", 32'(o), 32'd0);
    respond(o, 3, 32'h1234_5678, 1'b0, 1'b1);

    // Simultaneous requests after reset, both held: strict alternation from m0
    do_reset();
    set_master(0, 1'b1, 32'h0000_0400, 32'h0, 4'h0);
    set_master(1, 1'b0, 32'h0000_0800, 32'hA5A5_0001, 4'h3);
    for (int k = 0; k < 6; k++) begin
      arbitrate(o);
      check("alternation_owner", 32'(o), 32'(k % 2));
      respond(o, 1, 32'hC0DE_0000 + 32'(k), 1'b0, 1'b0);
    end
    mv = 2'b00;

    // m1 write to UART space
    set_master(1, 1'b0, 32'h2000_0000, 32'h0000_0041, 4'hF);
    arbitrate(o);
    check("m1_write_owner", 32'(o), 32'd1);
    respond(o, 2, 32'h0BAD_F00D, 1'b0, 1'b1);

    // Slave double ready: exactly one completion
    set_master(0, 1'b0, 32'h0000_0200, 32'h0, 4'h0);
    arbitrate(o);
    respond(o, 1, 32'h5555_AAAA, 1'b1, 1'b1);
    for (int i = 0; i < 2; i++) begin
      tick();
      check("double_ready_no_second", 32'({m1_ready, m0_ready}), 32'd0);
    end

    // m0 drops valid while owned: transaction still completes
    set_master(0, 1'b0, 32'h0000_0300, 32'h0, 4'h0);
    arbitrate(o);
    mv[0] = 1'b0;
    respond(o, 2, 32'h7777_0001, 1'b0, 1'b1);

    // Reset in BUSY with a concurrent slave ready: abandoned, no pulse
    set_master(1, 1'b0, 32'h0000_0500, 32'h0, 4'h0);
    arbitrate(o);
    tick();
    tick();
    resetn  = 1'b0;
    s_ready = 1'b1;
    s_rdata = 32'h1111_2222;
    tick();
    check("rst_busy_s_valid", 32'(s_valid), 32'd0);
    check("rst_busy_grant", 32'(grant), 32'd0);
    check("rst_busy_ready", 32'({m1_ready, m0_ready}), 32'd0);
    s_ready = 1'b0;
    mv = 2'b11;
    maddr[0] = 32'h0000_0600;
    tick();
    check("rst_busy_ready_hold", 32'({m1_ready, m0_ready}), 32'd0);
    resetn  = 1'b1;
    tb_last = 1'b1;
    arbitrate(o);
    check("post_reset_tie_owner", 32'(o), 32'd0);
    respond(o, 0, 32'h3333_0000, 1'b0, 1'b1);
    arbitrate(o);
    check("post_reset_second_owner", 32'(o), 32'd1);
    respond(o, 1, 32'h3333_0001, 1'b0, 1'b1);

    // Single-master transactions with varied fields and slave delays
    for (int k = 0; k < 6; k++) begin
      int m;
      m = $urandom_range(0, 1);
      set_master(m, 1'($urandom_range(0, 1)), $urandom & 32'hFFFF_FFFC, $urandom,
                 4'($urandom_range(0, 15)));
      arbitrate(o);
      check("single_owner", 32'(o), 32'(m));
      respond(o, $urandom_range(0, 4), $urandom, 1'($urandom_range(0, 1)), 1'b1);
    end

`ifdef MEM_ARB_TIMEOUT_EN
    // Slave never answers: timeout completion after 8 BUSY cycles
    set_master(0, 1'b0, 32'h0000_0700, 32'h0, 4'h0);
    arbitrate(o);
    sb.push_back('{owner: o, data: 32'hDEAD_BEEF});
    lat = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      lat++;
      if ((m0_ready | m1_ready) === 1'b1) break;
    end
    e = sb.pop_front();
    check("timeout_cycles", 32'(lat), 32'd8);
    check("timeout_ready", 32'({m1_ready, m0_ready}), 32'(oh(e.owner)));
    check("timeout_rdata", rd(e.owner), e.data);
    check("timeout_err_pulse", 32'(timeout_err), 32'd1);
    check("timeout_s_valid", 32'(s_valid), 32'd0);
    $display("txn: m%0d addr=0x%08h timeout rdata=0x%08h", e.owner, maddr[e.owner], rd(e.owner));
    mv[o] = 1'b0;
    tb_last = (o == 1);
    tick();
    check("timeout_err_clear", 32'(timeout_err), 32'd0);
    check("timeout_ready_clear", 32'({m1_ready, m0_ready}), 32'd0);
    check("timeout_grant_idle", 32'(grant), 32'd0);
    rdy_seen = 0;
    err_seen = 0;
`else
    // Slow slave without timeout: BUSY waits, no error, then normal completion
    set_master(0, 1'b0, 32'h0000_0700, 32'h0, 4'h0);
    arbitrate(o);
    rdy_seen = 0;
    err_seen = 0;
    lat = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if ((m0_ready | m1_ready) !== 1'b0) rdy_seen++;
      if (timeout_err !== 1'b0) err_seen++;
      if (s_valid !== 1'b1) lat++;
    end
    check("stall_no_ready", 32'(rdy_seen), 32'd0);
    check("stall_no_timeout_err", 32'(err_seen), 32'd0);
    check("stall_s_valid_held", 32'(lat), 32'd0);
    respond(o, 0, 32'h9999_0000, 1'b0, 1'b1);
`endif

    check("scoreboard_empty", 32'(sb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
